hilo_muldiv: RTL
================

// Module: hilo_muldiv
// PURPOSE
//  Producer side of the HI/LO write path. Executes MULT/MULTU/DIV/DIVU/MTHI/MTLO
//  and emits one write_hilo_t per accepted op. Sits in execute; its output feeds the
//  M/W pipeline registers that the HI/LO forwarding and HI/LO register file consume.
//  Multi-cycle ops hold ready low so the pipeline stalls until the result is out.
// PARAMETERS
//  WIDTH  32  operand/result half width; only 32 is supported (elaboration error otherwise)
// PORTS
//  clk     in   1         clock; all state updates on rising edge
//  reset   in   1         synchronous, active-high reset
//  start   in   1         op request; accepted when start && ready
//  op      in   muldiv_op_t  MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO
//  a       in   WIDTH     rs operand (dividend / multiplicand / MTHI,MTLO source)
//  b       in   WIDTH     rt operand (divisor / multiplier; ignored for MTHI/MTLO)
//  flush   in   1         exception/flush; kills the in-flight op
//  ready   out  1         1 only in IDLE
//  out     out  write_hilo_t  {valid_hi, valid_lo, hi, lo}; valid bits set only in DONE
// BEHAVIOUR
//  Reset: state=IDLE, ready=1, out all-zero, counter=0. Clock clk, reset is synchronous active-high.
//  Outside DONE, out is all-zero (valid bits 0, hi=lo=0).
//  States: IDLE -> (accept MTHI/MTLO or fast MUL) DONE; IDLE -> (accept MUL/DIV) CALC;
//   CALC (WIDTH cycles, counter WIDTH-1..0) -> FIX; FIX -> DONE; DONE -> IDLE.
//  Latency from accept edge E: MTHI/MTLO and fast MUL: out valid in the cycle after E.
//   Iterative MUL/DIV: out valid WIDTH+2 cycles after E (34 for WIDTH=32). DONE lasts 1 cycle.
//  Operands latched at E; a/b/op may change afterwards. start while !ready is ignored.
//  MTHI: valid_hi=1, hi=a, valid_lo=0. MTLO: valid_lo=1, lo=a, valid_hi=0.
//  MULT/MULTU: {hi,lo} = 2*WIDTH-bit signed/unsigned product; both valid bits 1.
//  DIV/DIVU: lo=quotient, hi=remainder, both valid. Signed: quotient truncates toward
//   zero, remainder takes sign of a. Computed as unsigned magnitudes; FIX applies signs.
//  Divide by zero: lo=all-ones, hi=a (both signed and unsigned); valid bits still 1.
//  Signed overflow (a=0x8000_0000, b=0xFFFF_FFFF): lo=0x8000_0000, hi=0.
//  flush: in CALC/FIX -> IDLE next cycle, no output. In DONE -> valid bits gated to 0
//   that same cycle (combinational), IDLE next. flush && start in IDLE -> start ignored.
//  reset mid-op: same as reset (IDLE next cycle, no output).
// CONFIGURATION
//  HILO_FAST_MUL_EN defined: MULT/MULTU use a single-cycle '*' product, IDLE->DONE.
//  Undefined: MULT/MULTU use WIDTH-step shift-add through CALC/FIX (sign fix in FIX),
//   same latency as DIV. MTHI/MTLO and DIV/DIVU unaffected either way.
// STRUCTURE
//  Shared header mycpu.svh: write_hilo_t (existing), new muldiv_op_t enum, MD_* values.
//  State enum and counter width local to this module.
//  Sub-module hilo_divider: unsigned restoring divider, one quotient bit per cycle;
//   ports clk, reset, load, dividend, divisor, step, quotient, remainder.
//   hilo_muldiv owns the FSM, sign handling, zero/overflow cases and the multiplier.
// TESTING
//  1 MTHI a=0x1234_5678 -> next cycle out={1,0,0x1234_5678,0}, ready=1 the cycle after.
//  2 MULT a=0xFFFF_FFFE(-2) b=3 -> hi=0xFFFF_FFFF lo=0xFFFF_FFFA; MULTU same operands
//    -> hi=0x2 lo=0xFFFF_FFFA; latency 1 (fast) / 34 (iterative), both builds run.
//  3 DIV a=-7 b=2 -> lo=0xFFFF_FFFD hi=0xFFFF_FFFF at E+34; DIVU a=7 b=2 -> lo=3 hi=1.
//  4 DIVU a=5 b=0 -> lo=0xFFFF_FFFF hi=5; DIV 0x8000_0000/-1 -> lo=0x8000_0000 hi=0.
//  5 DIV accepted, flush at E+10 -> no valid bit ever, ready=1 at E+11; start held
//    high while busy is not accepted a second time.
//  6 flush asserted in the DONE cycle -> valid bits 0; reset at E+5 -> out all-zero, IDLE.

Source files
------------

// File: rtl/hilo_muldiv_pkg.sv
// hilo_muldiv_pkg -- shared types for the HI/LO write path.
//   write_hilo_t : {valid_hi, valid_lo, hi, lo} record produced by hilo_muldiv
//   muldiv_op_t  : MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO
//   helpers      : op classification and two's-complement magnitude/negate
package hilo_muldiv_pkg;

  localparam int HILO_W = 32;

  typedef struct packed {
    logic              valid_hi;
    logic              valid_lo;
    logic [HILO_W-1:0] hi;
    logic [HILO_W-1:0] lo;
  } write_hilo_t;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } muldiv_op_t;

  function automatic logic op_is_mul(input muldiv_op_t op);
    case (op)
      MD_MULT, MD_MULTU: op_is_mul = 1'b1;
      default:           op_is_mul = 1'b0;
    endcase
  endfunction

  function automatic logic op_is_signed(input muldiv_op_t op);
    case (op)
      MD_MULT, MD_DIV: op_is_signed = 1'b1;
      default:         op_is_signed = 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] neg32(input logic [31:0] x);
    neg32 = ~x + 32'd1;
  endfunction

  function automatic logic [63:0] neg64(input logic [63:0] x);
    neg64 = ~x + 64'd1;
  endfunction

  // Unsigned magnitude; 0x8000_0000 maps to itself, which is the correct magnitude.
  function automatic logic [31:0] magnitude(input logic [31:0] x, input logic sgn);
    if (sgn && x[31]) begin
      magnitude = neg32(x);
    end else begin
      magnitude = x;
    end
  endfunction

endpackage

// File: rtl/hilo_divider.sv
// hilo_divider -- unsigned restoring divider, one quotient bit per step.
//   clk, reset          : clock, synchronous active-high reset
//   load                : capture dividend/divisor, clear partial remainder
//   dividend, divisor   : unsigned operands
//   step                : perform one shift/subtract iteration
//   quotient, remainder : valid after WIDTH steps following load
module hilo_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             step,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  logic [WIDTH-1:0] dsr;
  logic [WIDTH:0]   shifted;
  logic             fits;

  // Partial remainder shifted left with the next dividend bit, and the trial compare.
  always_comb begin
    shifted = {remainder, quotient[WIDTH-1]};
    fits    = (shifted >= {1'b0, dsr});
  end

  // The quotient register doubles as the dividend shift register.
  always_ff @(posedge clk) begin
    if (reset) begin
      quotient  <= {WIDTH{1'b0}};
      remainder <= {WIDTH{1'b0}};
      dsr       <= {WIDTH{1'b0}};
    end else if (load) begin
      quotient  <= dividend;
      remainder <= {WIDTH{1'b0}};
      dsr       <= divisor;
    end else if (step) begin
      quotient  <= {quotient[WIDTH-2:0], fits};
      remainder <= fits ? WIDTH'(shifted - {1'b0, dsr}) : shifted[WIDTH-1:0];
    end else begin
      quotient  <= quotient;
      remainder <= remainder;
      dsr       <= dsr;
    end
  end

endmodule

// File: rtl/hilo_muldiv.sv
// hilo_muldiv -- execute-stage MULT/MULTU/DIV/DIVU/MTHI/MTLO unit producing one
// write_hilo_t per accepted op.
//   clk, reset : clock, synchronous active-high reset
//   start, op  : request, accepted when start && ready (and no flush)
//   a, b       : rs / rt operands, latched at accept
//   flush      : kills an op in CALC/FIX; gates valid bits in DONE
//   ready      : high only in IDLE
//   out        : result record, all-zero outside DONE
// Build option: define HILO_FAST_MUL_EN for a single-cycle '*' multiplier;
// otherwise MULT/MULTU run a WIDTH-step shift-add with the same latency as DIV.
module hilo_muldiv
  import hilo_muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  muldiv_op_t       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             ready,
  output write_hilo_t      out
);

  if (WIDTH != HILO_W) begin : g_width_check
    $error("hilo_muldiv: only WIDTH=32 is supported");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam int               CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state, state_next;
  logic [CNT_W-1:0] count;
  logic             accept, fast_op;
  logic             mul_op, neg_lo, neg_hi, div_zero;
  logic [WIDTH-1:0] a_held;
  logic [WIDTH-1:0] quotient, remainder;
  logic             res_vhi, res_vlo;
  logic [WIDTH-1:0] res_hi, res_lo;
  logic             hold_vhi, hold_vlo;
  logic [WIDTH-1:0] hold_hi, hold_lo;
`ifndef HILO_FAST_MUL_EN
  logic [WIDTH-1:0] mcand, prod_hi, prod_lo;
  logic [WIDTH:0]   mul_sum;
`endif

  assign accept = (state == S_IDLE) && start && !flush;

  // Ops that finish straight from IDLE without the CALC/FIX pass.
  always_comb begin
    case (op)
      MD_MTHI, MD_MTLO:  fast_op = 1'b1;
`ifdef HILO_FAST_MUL_EN
      MD_MULT, MD_MULTU: fast_op = 1'b1;
`endif
      default:           fast_op = 1'b0;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state logic; flush aborts CALC/FIX without producing output.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_next = fast_op ? S_DONE : S_CALC;
        end else begin
          state_next = S_IDLE;
        end
      end
      S_CALC: begin
        if (flush) begin
          state_next = S_IDLE;
        end else if (count == {CNT_W{1'b0}}) begin
          state_next = S_FIX;
        end else begin
          state_next = S_CALC;
        end
      end
      S_FIX:   state_next = flush ? S_IDLE : S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // FSM outputs; flush masks the valid bits in the DONE cycle itself.
  always_comb begin
    ready = (state == S_IDLE);
    if (state == S_DONE) begin
      out.valid_hi = hold_vhi && !flush;
      out.valid_lo = hold_vlo && !flush;
      out.hi       = hold_hi;
      out.lo       = hold_lo;
    end else begin
      out.valid_hi = 1'b0;
      out.valid_lo = 1'b0;
      out.hi       = {WIDTH{1'b0}};
      out.lo       = {WIDTH{1'b0}};
    end
  end

  // Operand attributes latched at accept, plus the CALC iteration counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      count    <= {CNT_W{1'b0}};
      mul_op   <= 1'b0;
      neg_lo   <= 1'b0;
      neg_hi   <= 1'b0;
      div_zero <= 1'b0;
      a_held   <= {WIDTH{1'b0}};
    end else if (accept) begin
      count    <= CNT_LAST;
      mul_op   <= op_is_mul(op);
      // neg_lo: sign of product / quotient; neg_hi: remainder follows the dividend.
      neg_lo   <= op_is_signed(op) && (a[WIDTH-1] ^ b[WIDTH-1]);
      neg_hi   <= op_is_signed(op) && a[WIDTH-1];
      div_zero <= (b == {WIDTH{1'b0}});
      a_held   <= a;
    end else if (state == S_CALC) begin
      count    <= count - CNT_W'(1);
    end else begin
      count    <= count;
    end
  end

  hilo_divider #(.WIDTH(WIDTH)) u_divider (
    .clk       (clk),
    .reset     (reset),
    .load      (accept),
    .dividend  (magnitude(a, op_is_signed(op))),
    .divisor   (magnitude(b, op_is_signed(op))),
    .step      ((state == S_CALC) && !mul_op),
    .quotient  (quotient),
    .remainder (remainder)
  );

`ifndef HILO_FAST_MUL_EN
  // One shift-add partial sum: add the multiplicand when the low multiplier bit is set.
  always_comb begin
    if (prod_lo[0]) begin
      mul_sum = {1'b0, prod_hi} + {1'b0, mcand};
    end else begin
      mul_sum = {1'b0, prod_hi};
    end
  end

  // Unsigned shift-add multiplier on magnitudes; {prod_hi, prod_lo} shifts right each step.
  always_ff @(posedge clk) begin
    if (reset) begin
      mcand   <= {WIDTH{1'b0}};
      prod_hi <= {WIDTH{1'b0}};
      prod_lo <= {WIDTH{1'b0}};
    end else if (accept) begin
      mcand   <= magnitude(a, op_is_signed(op));
      prod_hi <= {WIDTH{1'b0}};
      prod_lo <= magnitude(b, op_is_signed(op));
    end else if ((state == S_CALC) && mul_op) begin
      prod_hi <= mul_sum[WIDTH:1];
      prod_lo <= {mul_sum[0], prod_lo[WIDTH-1:1]};
    end else begin
      mcand   <= mcand;
      prod_hi <= prod_hi;
      prod_lo <= prod_lo;
    end
  end
`endif

  // Result selection: live operands for IDLE->DONE ops, sign fix-up for CALC results.
  // Signed overflow (0x8000_0000 / -1) needs no special case: magnitude 0x8000_0000/1
  // with a positive quotient sign already yields lo=0x8000_0000, hi=0.
  always_comb begin
    res_vhi = 1'b0;
    res_vlo = 1'b0;
    res_hi  = {WIDTH{1'b0}};
    res_lo  = {WIDTH{1'b0}};
    if (state == S_IDLE) begin
      case (op)
        MD_MTHI: begin
          res_vhi = 1'b1;
          res_hi  = a;
        end
        MD_MTLO: begin
          res_vlo = 1'b1;
          res_lo  = a;
        end
`ifdef HILO_FAST_MUL_EN
        MD_MULT: begin
          res_vhi          = 1'b1;
          res_vlo          = 1'b1;
          {res_hi, res_lo} = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
        end
        MD_MULTU: begin
          res_vhi          = 1'b1;
          res_vlo          = 1'b1;
          {res_hi, res_lo} = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
        end
`endif
        default: begin
          res_vhi = 1'b0;
        end
      endcase
    end else if (mul_op) begin
`ifndef HILO_FAST_MUL_EN
      res_vhi          = 1'b1;
      res_vlo          = 1'b1;
      {res_hi, res_lo} = neg_lo ? neg64({prod_hi, prod_lo}) : {prod_hi, prod_lo};
`else
      res_vhi = 1'b0;
`endif
    end else if (div_zero) begin
      res_vhi = 1'b1;
      res_vlo = 1'b1;
      res_hi  = a_held;
      res_lo  = {WIDTH{1'b1}};
    end else begin
      res_vhi = 1'b1;
      res_vlo = 1'b1;
      res_lo  = neg_lo ? neg32(quotient) : quotient;
      res_hi  = neg_hi ? neg32(remainder) : remainder;
    end
  end

  // Result holding register, loaded on every transition into DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_vhi <= 1'b0;
      hold_vlo <= 1'b0;
      hold_hi  <= {WIDTH{1'b0}};
      hold_lo  <= {WIDTH{1'b0}};
    end else if (state_next == S_DONE) begin
      hold_vhi <= res_vhi;
      hold_vlo <= res_vlo;
      hold_hi  <= res_hi;
      hold_lo  <= res_lo;
    end else begin
      hold_vhi <= hold_vhi;
      hold_vlo <= hold_vlo;
      hold_hi  <= hold_hi;
      hold_lo  <= hold_lo;
    end
  end

endmodule
